gen_reg_file_sb: RTL and testbench
==================================

Name: gen_reg_file_sb

Overview:
Parametrised successor to the three-read-port general register file. It adds:
- configurable read-port count, depth and width;
- an optional hardwired zero register;
- write-to-read bypass;
- a per-register pending-write scoreboard for the pipeline's hazard logic;
- a sequential clear engine that sweeps storage to zero after reset or on request.

It sits between decode (read and claim) and writeback (write) in the processor datapath.

Parameters:
NUM_REG, 16, number of registers; power of two, ≥2
SEL_WIDTH, 4, register-address width; $clog2(NUM_REG)
D_WIDTH, 34, data width
NUM_RD, 3, number of read ports, 1..4
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and claims
BYPASS, 1, 1 = same-cycle write data forwarded to matching reads

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
clr_req_i  in  1  request full storage clear (pulse)
ready_o  out  1  1 = RUN state, port accepts traffic
wen_i  in  1  write enable
wa_i  in  SEL_WIDTH  write address
wd_i  in  D_WIDTH  write data
ra_i  in  NUM_RD*SEL_WIDTH  read addresses, port k at [k*SEL_WIDTH +: SEL_WIDTH]
rd_o  out  NUM_RD*D_WIDTH  read data, port k at [k*D_WIDTH +: D_WIDTH]
rd_pend_o  out  NUM_RD  1 = addressed register has an outstanding claim
claim_i  in  1  mark register as awaiting writeback
claim_a_i  in  SEL_WIDTH  register being claimed
pending_o  out  NUM_REG  scoreboard bitmap

Behaviour:
- States: CLEAR, RUN.
- Reset (rst_n low, async) forces CLEAR with clear counter = 0 and pending = 0.
  - Outputs during reset: ready_o = 0, rd_o = 0, rd_pend_o = 0, pending_o = 0.
  - Storage array is not reset; the clear engine zeroes it.
- CLEAR:
  - Writes register[cnt] = 0 each cycle, then cnt++.
  - After cnt = NUM_REG-1 is written, the next state is RUN. ready_o rises exactly NUM_REG cycles after rst_n deasserts.
  - While in CLEAR: wen_i, claim_i and clr_req_i are ignored; rd_o = 0; rd_pend_o = 0.
- RUN:
  - clr_req_i = 1 → CLEAR next cycle, cnt = 0, pending cleared at that edge.
  - Any write or claim in that same cycle is dropped.
- Write: when ready_o && wen_i, register[wa_i] ← wd_i at the rising edge. Suppressed when ZERO_REG && wa_i = 0.
- Read:
  - Combinational: rd_o[k] = register[ra_k].
  - ZERO_REG && ra_k = 0 → 0.
  - BYPASS && ready_o && wen_i && wa_i = ra_k (and not the zero register) → wd_i.
- Scoreboard, evaluated at the edge when ready_o:
  - claim_i sets pending[claim_a_i].
  - wen_i clears pending[wa_i].
  - Claim and write to the same register in one cycle → pending stays 1; the new claim wins.
  - Claim of an already-pending register → stays 1; no count, single outstanding claim.
  - ZERO_REG: claims of register 0 are ignored and pending[0] is always 0.
- rd_pend_o[k] = pending[ra_k], forced to 0 when BYPASS and the bypass condition above holds for port k.
- rst_n asserted mid-sweep restarts the sweep from 0.

Decomposition:
- Shared package gen_reg_pkg: state enum {CLEAR, RUN}, default constants (NUM_REG, D_WIDTH, NUM_RD).
- One sub-module, reg_scoreboard: pending bitmap, claim/clear logic, flush input driven from the FSM.
- Storage, bypass mux and FSM stay in the top level.

Test Plan:
- Reset release, NUM_REG=16 → ready_o = 0 for 16 cycles, 1 on cycle 16; every rd_o = 0 after the sweep.
- Write reg 5 = 34'h2_DEAD_BEEF, next cycle ra port 1 = 5 → rd_o port 1 = 34'h2_DEAD_BEEF; port 0 reading 3 = 0.
- Same cycle wen_i = 1, wa_i = 7, wd_i = 34'h123, ra port 2 = 7 → rd_o port 2 = 34'h123 in that cycle; rd_pend_o[2] = 0 even though reg 7 is pending.
- ZERO_REG = 1: write reg 0 = 34'h3FF, claim reg 0 → rd_o reads 0, pending_o[0] = 0.
- Claim reg 9 → pending_o = 16'h0200. Then claim 9 and write 9 in the same cycle → still 16'h0200. Then write 9 alone → 16'h0000.
- RUN with pending = 16'h00F0 and reg 4 = 34'h55, pulse clr_req_i → ready_o = 0 next cycle, pending_o = 0, ready_o returns after 16 cycles, reg 4 reads 0. Repeat with rst_n pulsed at sweep cycle 8 → full 16-cycle restart.

Source files
------------

// File: rtl/gen_reg_file_sb_pkg.sv
// gen_reg_pkg: shared state encoding and default sizing for the scoreboarded register file.
package gen_reg_pkg;
  typedef enum logic {CLEAR, RUN} state_e;
  localparam int DEF_NUM_REG = 16;
  localparam int DEF_D_WIDTH = 34;
  localparam int DEF_NUM_RD  = 3;
endpackage

// File: rtl/gen_reg_file_sb_if.sv
// gen_reg_file_sb_if: register-file access bundle.
//   master (decode/writeback side) drives clr_req_i, wen_i, wa_i, wd_i, ra_i, claim_i, claim_a_i
//   slave  (register file) drives ready_o, rd_o, rd_pend_o, pending_o
interface gen_reg_file_sb_if #(
  parameter int NUM_REG   = 16,
  parameter int SEL_WIDTH = $clog2(NUM_REG),
  parameter int D_WIDTH   = 34,
  parameter int NUM_RD    = 3
);
  logic                        clr_req_i;
  logic                        ready_o;
  logic                        wen_i;
  logic [SEL_WIDTH-1:0]        wa_i;
  logic [D_WIDTH-1:0]          wd_i;
  logic [NUM_RD*SEL_WIDTH-1:0] ra_i;
  logic [NUM_RD*D_WIDTH-1:0]   rd_o;
  logic [NUM_RD-1:0]           rd_pend_o;
  logic                        claim_i;
  logic [SEL_WIDTH-1:0]        claim_a_i;
  logic [NUM_REG-1:0]          pending_o;
  modport master (
    output clr_req_i, wen_i, wa_i, wd_i, ra_i, claim_i, claim_a_i,
    input  ready_o, rd_o, rd_pend_o, pending_o
  );
  modport slave (
    input  clr_req_i, wen_i, wa_i, wd_i, ra_i, claim_i, claim_a_i,
    output ready_o, rd_o, rd_pend_o, pending_o
  );
endinterface

// File: rtl/gen_reg_file_sb_scoreboard.sv
// reg_scoreboard: per-register pending-write bitmap.
//   en_i      : traffic accepted this cycle (RUN and no clear request)
//   flush_i   : drop every outstanding claim at this edge
//   wen_i/wa_i: writeback retires the claim on wa_i
//   claim_i/claim_a_i: decode marks claim_a_i as awaiting writeback
//   pending_o : bitmap, bit r = register r has an outstanding claim
module reg_scoreboard #(
  parameter int NUM_REG   = 16,
  parameter int SEL_WIDTH = $clog2(NUM_REG),
  parameter int ZERO_REG  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en_i,
  input  logic                 flush_i,
  input  logic                 wen_i,
  input  logic [SEL_WIDTH-1:0] wa_i,
  input  logic                 claim_i,
  input  logic [SEL_WIDTH-1:0] claim_a_i,
  output logic [NUM_REG-1:0]   pending_o
);
  logic [NUM_REG-1:0] pending_q, pending_d;
  // Claim is applied after the retire so a same-cycle claim of the written register wins.
  always_comb begin
    pending_d = pending_q;
    if (flush_i) pending_d = '0;
    else if (en_i) begin
      if (wen_i) pending_d[wa_i] = 1'b0;
      if (claim_i) pending_d[claim_a_i] = 1'b1;
    end
    if (ZERO_REG != 0) pending_d[0] = 1'b0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pending_q <= '0;
    else pending_q <= pending_d;
  assign pending_o = pending_q;
endmodule

// File: rtl/gen_reg_file_sb.sv
// gen_reg_file_sb: multi-port register file with zero register, write bypass, claim scoreboard and clear sweep.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : slave side of gen_reg_file_sb_if (write, reads, claims, clear request, status)
module gen_reg_file_sb
  import gen_reg_pkg::*;
#(
  parameter int NUM_REG   = DEF_NUM_REG,
  parameter int SEL_WIDTH = $clog2(NUM_REG),
  parameter int D_WIDTH   = DEF_D_WIDTH,
  parameter int NUM_RD    = DEF_NUM_RD,
  parameter int ZERO_REG  = 1,
  parameter int BYPASS    = 1
) (
  input logic              clk,
  input logic              rst_n,
  gen_reg_file_sb_if.slave bus
);
  state_e               state_q, state_d;
  logic [SEL_WIDTH-1:0] cnt_q, cnt_d;
  logic [D_WIDTH-1:0]   mem_q [NUM_REG];
  logic [NUM_REG-1:0]   pending;
  logic                 ready, accept, wr_en;
  assign ready       = state_q == RUN;
  assign accept      = ready && !bus.clr_req_i;
  assign wr_en       = accept && bus.wen_i && !(ZERO_REG != 0 && bus.wa_i == '0);
  assign bus.ready_o = ready;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == CLEAR) begin
      cnt_d   = cnt_q + 1'b1;
      state_d = cnt_q == SEL_WIDTH'(NUM_REG - 1) ? RUN : CLEAR;
    end else if (bus.clr_req_i) begin
      cnt_d   = '0;
      state_d = CLEAR;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  // Storage has no reset; the sweep zeroes one entry per cycle while not in RUN.
  always_ff @(posedge clk)
    if (!ready) mem_q[cnt_q] <= '0;
    else if (wr_en) mem_q[bus.wa_i] <= bus.wd_i;
  reg_scoreboard #(
    .NUM_REG  (NUM_REG),
    .SEL_WIDTH(SEL_WIDTH),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     (accept),
    .flush_i  (ready && bus.clr_req_i),
    .wen_i    (bus.wen_i),
    .wa_i     (bus.wa_i),
    .claim_i  (bus.claim_i),
    .claim_a_i(bus.claim_a_i),
    .pending_o(pending)
  );
  assign bus.pending_o = pending;
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [SEL_WIDTH-1:0] ra;
    logic                 zr, byp;
    assign ra  = bus.ra_i[k*SEL_WIDTH +: SEL_WIDTH];
    assign zr  = ZERO_REG != 0 && ra == '0;
    // A forwarded write satisfies the claim, so the port sees it as not pending.
    assign byp = BYPASS != 0 && ready && bus.wen_i && bus.wa_i == ra && !zr;
    assign bus.rd_o[k*D_WIDTH +: D_WIDTH] = (!ready || zr) ? '0 : byp ? bus.wd_i : mem_q[ra];
    assign bus.rd_pend_o[k] = ready && !byp && pending[ra];
  end
endmodule

// File: tb/tb_gen_reg_file_sb.sv
// tb_gen_reg_file_sb: directed self-checking bench for gen_reg_file_sb.
module tb_gen_reg_file_sb;
  localparam int NR = 16;
  localparam int SW = 4;
  localparam int DW = 34;
  localparam int RD = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  gen_reg_file_sb_if #(.NUM_REG(NR), .SEL_WIDTH(SW), .D_WIDTH(DW), .NUM_RD(RD)) bus ();
  gen_reg_file_sb #(
    .NUM_REG(NR), .SEL_WIDTH(SW), .D_WIDTH(DW), .NUM_RD(RD), .ZERO_REG(1), .BYPASS(1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_ra(input logic [SW-1:0] a0, input logic [SW-1:0] a1, input logic [SW-1:0] a2);
    bus.ra_i = {a2, a1, a0};
  endtask
  function automatic logic [DW-1:0] rdp(input int k);
    return bus.rd_o[k*DW +: DW];
  endfunction
  task automatic idle();
    bus.clr_req_i = 1'b0;
    bus.wen_i     = 1'b0;
    bus.wa_i      = '0;
    bus.wd_i      = '0;
    bus.claim_i   = 1'b0;
    bus.claim_a_i = '0;
  endtask
  task automatic sweep16(input string tag);
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk(tag, 64'(bus.ready_o), 64'(i == 16));
    end
  endtask
  initial begin
    idle();
    set_ra(0, 1, 2);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 64'(bus.ready_o), 64'd0);
    chk("rst_rd", 64'(bus.rd_o != '0), 64'd0);
    chk("rst_rd_pend", 64'(bus.rd_pend_o), 64'd0);
    chk("rst_pending", 64'(bus.pending_o), 64'd0);
    rst_n = 1'b1;
    sweep16("rel_ready");
    for (int r = 0; r < NR; r++) begin
      set_ra(SW'(r), SW'(r), SW'(r));
      #1;
      chk("swept_rd", 64'(bus.rd_o), 64'd0);
    end
    bus.wen_i = 1'b1; bus.wa_i = 4'd5; bus.wd_i = 34'h2_DEAD_BEEF;
    tick();
    idle();
    set_ra(3, 5, 0);
    #1;
    chk("rd_p1_reg5", 64'(rdp(1)), 64'h2_DEAD_BEEF);
    chk("rd_p0_reg3", 64'(rdp(0)), 64'd0);
    bus.claim_i = 1'b1; bus.claim_a_i = 4'd7;
    tick();
    idle();
    chk("pend_7", 64'(bus.pending_o), 64'h0080);
    set_ra(7, 5, 7);
    #1;
    chk("rd_pend_7", 64'(bus.rd_pend_o), 64'b101);
    bus.wen_i = 1'b1; bus.wa_i = 4'd7; bus.wd_i = 34'h123;
    #1;
    chk("bypass_p2", 64'(rdp(2)), 64'h123);
    chk("bypass_pend", 64'(bus.rd_pend_o), 64'b000);
    chk("bypass_p1", 64'(rdp(1)), 64'h2_DEAD_BEEF);
    tick();
    idle();
    chk("pend_7_clr", 64'(bus.pending_o), 64'h0000);
    chk("stored_7", 64'(rdp(2)), 64'h123);
    bus.wen_i = 1'b1; bus.wa_i = 4'd0; bus.wd_i = 34'h3FF;
    bus.claim_i = 1'b1; bus.claim_a_i = 4'd0;
    set_ra(0, 0, 0);
    #1;
    chk("zero_nobyp", 64'(rdp(0)), 64'd0);
    tick();
    idle();
    chk("zero_rd", 64'(rdp(0)), 64'd0);
    chk("zero_pend", 64'(bus.pending_o), 64'h0000);
    bus.claim_i = 1'b1; bus.claim_a_i = 4'd9;
    tick();
    idle();
    chk("claim9", 64'(bus.pending_o), 64'h0200);
    set_ra(9, 9, 9);
    #1;
    chk("rd_pend_9", 64'(bus.rd_pend_o), 64'b111);
    bus.claim_i = 1'b1; bus.claim_a_i = 4'd9;
    bus.wen_i = 1'b1; bus.wa_i = 4'd9; bus.wd_i = 34'h77;
    tick();
    idle();
    chk("claim_wr9", 64'(bus.pending_o), 64'h0200);
    bus.claim_i = 1'b1; bus.claim_a_i = 4'd9;
    tick();
    idle();
    chk("reclaim9", 64'(bus.pending_o), 64'h0200);
    bus.wen_i = 1'b1; bus.wa_i = 4'd9; bus.wd_i = 34'h78;
    tick();
    idle();
    chk("wr9", 64'(bus.pending_o), 64'h0000);
    chk("rd9", 64'(rdp(0)), 64'h78);
    bus.wen_i = 1'b1; bus.wa_i = 4'd4; bus.wd_i = 34'h55;
    tick();
    idle();
    for (int r = 4; r < 8; r++) begin
      bus.claim_i = 1'b1; bus.claim_a_i = SW'(r);
      tick();
    end
    idle();
    set_ra(4, 8, 6);
    #1;
    chk("pend_f0", 64'(bus.pending_o), 64'h00F0);
    chk("rd4_55", 64'(rdp(0)), 64'h55);
    chk("rd_pend_f0", 64'(bus.rd_pend_o), 64'b101);
    bus.clr_req_i = 1'b1;
    bus.wen_i = 1'b1; bus.wa_i = 4'd8; bus.wd_i = 34'hAA;
    tick();
    idle();
    chk("clr_ready", 64'(bus.ready_o), 64'd0);
    chk("clr_pend", 64'(bus.pending_o), 64'h0000);
    chk("clr_rd", 64'(bus.rd_o), 64'd0);
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("clr_sweep", 64'(bus.ready_o), 64'(i == 16));
      if (i == 3) begin
        bus.wen_i = 1'b1; bus.wa_i = 4'd4; bus.wd_i = 34'hAA;
        bus.claim_i = 1'b1; bus.claim_a_i = 4'd3;
        set_ra(4, 4, 4);
        #1;
        chk("clear_nobyp", 64'(rdp(0)), 64'd0);
        chk("clear_rd_pend", 64'(bus.rd_pend_o), 64'd0);
      end
      if (i == 4) begin
        chk("clear_noclaim", 64'(bus.pending_o), 64'h0000);
        idle();
      end
    end
    set_ra(4, 8, 3);
    #1;
    chk("clr_rd4", 64'(rdp(0)), 64'd0);
    chk("clr_rd8", 64'(rdp(1)), 64'd0);
    bus.clr_req_i = 1'b1;
    tick();
    idle();
    repeat (8) tick();
    chk("mid_ready_lo", 64'(bus.ready_o), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 64'(bus.ready_o), 64'd0);
    chk("mid_rst_pend", 64'(bus.pending_o), 64'h0000);
    tick();
    rst_n = 1'b1;
    sweep16("restart");
    set_ra(4, 15, 0);
    #1;
    chk("restart_rd", 64'(bus.rd_o), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
